// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button front end.
package btn_pkg;

  typedef enum logic [1:0] {ST_LO, ST_CHK_HI, ST_HI, ST_CHK_LO} btn_state_t;

  localparam int CLK_HZ               = 50_000_000;
  localparam int DEBOUNCE_MS          = 10;
  localparam int DEBOUNCE_CYCLES_DFLT = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int LONG_CYCLES_DFLT     = CLK_HZ;

endpackage

// File: rtl/btn_sync.sv
// STAGES-deep synchroniser for an asynchronous level; flops reset to RST_VAL.
module btn_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button front end: synchronise, debounce, emit clean level and rise/fall strobes.
// Define BTN_LONGPRESS_EN to add the o_long hold strobe.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter int SYNC_STAGES     = 2,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int LONG_CYCLES     = LONG_CYCLES_DFLT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_raw,
  output logic o_btn,
  output logic o_pos,
`ifdef BTN_LONGPRESS_EN
  output logic o_long,
`endif
  output logic o_neg
);

  localparam logic ACT_LO = (BTN_ACTIVE_LOW != 0);
  localparam int   CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2 || LONG_CYCLES < 1) begin : g_bad_param
    $error("btn_debounce: DEBOUNCE_CYCLES/LONG_CYCLES must be >= 1, SYNC_STAGES >= 2");
  end

  logic sync_q;
  logic s;

  btn_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (ACT_LO)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_btn_raw),
    .o_q     (sync_q)
  );

  assign s = sync_q ^ ACT_LO;

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;
  logic             pos_q, pos_d;
  logic             neg_q, neg_d;

`ifdef BTN_LONGPRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn_d   = btn_q;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    case (state_q)
      ST_LO: begin
        if (s) begin
          state_d = ST_CHK_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_CHK_HI: begin
        if (!s) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_HI;
          cnt_d   = '0;
          btn_d   = 1'b1;
          pos_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HI: begin
        if (!s) begin
          state_d = ST_CHK_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_CHK_LO: begin
        if (s) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_LO;
          cnt_d   = '0;
          btn_d   = 1'b0;
          neg_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
      end
    endcase

`ifdef BTN_LONGPRESS_EN
    // Hold time is measured from o_pos; saturation prevents a second strobe.
    hold_d = hold_q;
    long_d = 1'b0;
    if (pos_d) begin
      hold_d = '0;
    end else if ((state_q == ST_HI || state_q == ST_CHK_LO) && hold_q != HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
      long_d = (hold_q == HOLD_PRE);
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
`ifdef BTN_LONGPRESS_EN
      hold_q  <= '0;
      long_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
`ifdef BTN_LONGPRESS_EN
      hold_q  <= hold_d;
      long_q  <= long_d;
`endif
    end
  end

  assign o_btn = btn_q;
  assign o_pos = pos_q;
  assign o_neg = neg_q;
`ifdef BTN_LONGPRESS_EN
  assign o_long = long_q;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce; strobes are matched against a queue of expected events.
module tb_btn_debounce;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int LONG = 20;
  localparam int LAT  = SYNC + DEB;
  localparam int K_POS  = 0;
  localparam int K_NEG  = 1;
  localparam int K_LONG = 2;

  logic i_clk = 1'b0;
  logic i_rst_n;
  logic i_btn_raw;
  logic o_btn, o_pos, o_neg;
`ifdef BTN_LONGPRESS_EN
  logic o_long;
`endif

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t q[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  t0       = 0;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC),
    .BTN_ACTIVE_LOW  (1),
    .LONG_CYCLES     (LONG)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_btn_raw (i_btn_raw),
    .o_btn     (o_btn),
    .o_pos     (o_pos),
`ifdef BTN_LONGPRESS_EN
    .o_long    (o_long),
`endif
    .o_neg     (o_neg)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Consume one observed strobe against the oldest expected event.
  task automatic got(input int k, input logic btn);
    ev_t e;
    if (q.size() == 0) begin
      chk("unexpected_strobe_kind", k, -1);
    end else begin
      e = q.pop_front();
      chk("strobe_kind", k, e.kind);
      chk("strobe_cycle", cyc, e.cyc);
      if (k == K_POS) chk("btn_with_pos", btn, 1);
      if (k == K_NEG) chk("btn_with_neg", btn, 0);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n === 1'b1) begin
      if (o_pos === 1'b1 && o_neg === 1'b1) chk("pos_neg_overlap", 1, 0);
      if (o_pos !== 1'b0) got(K_POS, o_btn);
      if (o_neg !== 1'b0) got(K_NEG, o_btn);
`ifdef BTN_LONGPRESS_EN
      if (o_long !== 1'b0) got(K_LONG, o_btn);
`endif
    end
  end

  task automatic drive(input logic v);
    @(negedge i_clk);
    i_btn_raw = v;
    t0 = cyc + 1;
  endtask

  task automatic expect_ev(input int k, input int at);
    ev_t e;
    e.kind = k;
    e.cyc  = at;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with button released
    i_rst_n   = 1'b0;
    i_btn_raw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      chk("rst_btn", o_btn, 0);
      chk("rst_pos", o_pos, 0);
      chk("rst_neg", o_neg, 0);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(10);
    chk("idle_btn", o_btn, 0);

    // Clean press: exact latency and single-cycle strobe
    drive(1'b0);
    expect_ev(K_POS, t0 + LAT);
    idle(LAT);
    chk("press_early_btn", o_btn, 0);
    chk("press_early_pos", o_pos, 0);
    idle(1);
    chk("press_btn", o_btn, 1);
    chk("press_pos", o_pos, 1);
    idle(1);
    chk("press_pos_drop", o_pos, 0);
    chk("press_btn_hold", o_btn, 1);
    idle(4);

    // Clean release
    drive(1'b1);
    expect_ev(K_NEG, t0 + LAT);
    idle(LAT);
    chk("release_early_btn", o_btn, 1);
    idle(1);
    chk("release_btn", o_btn, 0);
    chk("release_neg", o_neg, 1);
    idle(1);
    chk("release_neg_drop", o_neg, 0);
    idle(4);

    // Short glitch (3 cycles) rejected
    drive(1'b0);
    idle(2);
    drive(1'b1);
    idle(12);
    chk("glitch3_btn", o_btn, 0);

    // Boundary: exactly DEB cycles low is still rejected
    drive(1'b0);
    idle(DEB - 1);
    drive(1'b1);
    idle(12);
    chk("glitch4_btn", o_btn, 0);

    // DEB+1 cycles low is accepted, then released
    drive(1'b0);
    expect_ev(K_POS, t0 + LAT);
    idle(DEB);
    drive(1'b1);
    expect_ev(K_NEG, t0 + LAT);
    idle(LAT + 4);
    chk("short_press_btn", o_btn, 0);

    // Four bounces then steady press: one o_pos only
    for (int i = 0; i < 4; i++) begin
      drive(1'b0);
      idle(1);
      drive(1'b1);
      idle(1);
    end
    drive(1'b0);
    expect_ev(K_POS, t0 + LAT);
    idle(LAT + 4);
    chk("bounce_press_btn", o_btn, 1);

    // Release glitch while pressed is rejected
    drive(1'b1);
    idle(2);
    drive(1'b0);
    idle(12);
    chk("hi_glitch_btn", o_btn, 1);
    drive(1'b1);
    expect_ev(K_NEG, t0 + LAT);
    idle(LAT + 4);
    chk("bounce_release_btn", o_btn, 0);

    // Async reset while qualifying a press
    drive(1'b0);
    idle(2);
    #2 i_rst_n = 1'b0;
    q.delete();
    #1;
    chk("rst_chk_btn", o_btn, 0);
    chk("rst_chk_pos", o_pos, 0);
    chk("rst_chk_neg", o_neg, 0);
    idle(2);
    i_rst_n = 1'b1;
    t0 = cyc + 1;
    expect_ev(K_POS, t0 + LAT);
    idle(LAT + 2);
    chk("held_after_rst_btn", o_btn, 1);

    // Async reset while pressed: output drops before any clock edge
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_hi_btn", o_btn, 0);
    chk("rst_hi_pos", o_pos, 0);
    idle(2);
    i_rst_n = 1'b1;
    t0 = cyc + 1;
    expect_ev(K_POS, t0 + LAT);
    idle(LAT + 2);
    chk("held_after_rst2_btn", o_btn, 1);
    drive(1'b1);
    expect_ev(K_NEG, t0 + LAT);
    idle(LAT + 4);
    chk("rst_release_btn", o_btn, 0);

`ifdef BTN_LONGPRESS_EN
    // Long hold: one o_long LONG cycles after o_pos, no repeat
    drive(1'b0);
    expect_ev(K_POS, t0 + LAT);
    expect_ev(K_LONG, t0 + LAT + LONG);
    idle(39);
    drive(1'b1);
    expect_ev(K_NEG, t0 + LAT);
    idle(LAT + 4);
    chk("long_release_btn", o_btn, 0);

    // Release after 15 cycles: no o_long
    drive(1'b0);
    expect_ev(K_POS, t0 + LAT);
    idle(14);
    drive(1'b1);
    expect_ev(K_NEG, t0 + LAT);
    idle(LAT + LONG + 4);
    chk("short_hold_btn", o_btn, 0);
`endif

    chk("events_outstanding", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
